// File: rtl/xgemac_wb_regs.sv
// XGE MAC wishbone register block: CONFIG, SCRATCH, interrupt pending/status/mask.
// Single-cycle classic responder; pending bits are edge-set and clear-on-read.
module xgemac_wb_regs #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int NUM_INT = 9
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [AW-1:0]      wb_adr_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [DW-1:0]      wb_dat_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_int_o,
  input  logic [NUM_INT-1:0] status_i,
  output logic               ctrl_tx_enable_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} state_t;

  localparam logic [AW-3:0] A_CONFIG  = 'd0;
  localparam logic [AW-3:0] A_SCRATCH = 'd1;
  localparam logic [AW-3:0] A_PENDING = 'd2;
  localparam logic [AW-3:0] A_STATUS  = 'd3;
  localparam logic [AW-3:0] A_MASK    = 'd4;

  state_t             state, state_nxt;
  logic               tx_enable;
  logic [DW-1:0]      scratch;
  logic [NUM_INT-1:0] int_mask;
  logic [NUM_INT-1:0] pending, pending_nxt;
  logic [NUM_INT-1:0] status_q;
  logic [DW-1:0]      rd_data;
  logic [AW-3:0]      adr_word;
  logic               accept;
  logic               rd_clear;
  logic [1:0]         unused_byte_lane;

  assign adr_word         = wb_adr_i[AW-1:2];
  assign unused_byte_lane = wb_adr_i[1:0];
  assign accept           = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign rd_clear         = accept && !wb_we_i && (adr_word == A_PENDING);

  // A new edge on the clearing read's commit edge wins over the clear.
  assign pending_nxt = (rd_clear ? '0 : pending) | (status_i & ~status_q);

  assign wb_ack_o         = (state == ST_ACK);
  assign wb_int_o         = |(pending & int_mask);
  assign ctrl_tx_enable_o = tx_enable;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE: if (wb_cyc_i && wb_stb_i) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (adr_word)
      A_CONFIG:  rd_data[0]           = tx_enable;
      A_SCRATCH: rd_data              = scratch;
      A_PENDING: rd_data[NUM_INT-1:0] = pending;
      A_STATUS:  rd_data[NUM_INT-1:0] = status_i;
      A_MASK:    rd_data[NUM_INT-1:0] = int_mask;
      default:   rd_data              = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      tx_enable <= 1'b0;
      scratch   <= '0;
      int_mask  <= '0;
      pending   <= '0;
      status_q  <= '0;
      wb_dat_o  <= '0;
    end else begin
      state    <= state_nxt;
      status_q <= status_i;
      pending  <= pending_nxt;
      if (accept) begin
        if (wb_we_i) begin
          case (adr_word)
            A_CONFIG:  tx_enable <= wb_dat_i[0];
            A_SCRATCH: scratch   <= wb_dat_i;
            A_MASK:    int_mask  <= wb_dat_i[NUM_INT-1:0];
            default:   ;
          endcase
        end else begin
          wb_dat_o <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_xgemac_wb_regs.sv
// Directed bench for xgemac_wb_regs: register access, ack timing, interrupt
// pending/mask behaviour, clear-on-read race and reset during an access.
module tb_xgemac_wb_regs;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [7:0]  wb_adr_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_int_o;
  logic [8:0]  status_i = '0;
  logic        ctrl_tx_enable_o;

  int tests_run = 0;
  int tests_failed = 0;

  xgemac_wb_regs dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .wb_adr_i        (wb_adr_i),
    .wb_cyc_i        (wb_cyc_i),
    .wb_stb_i        (wb_stb_i),
    .wb_we_i         (wb_we_i),
    .wb_dat_i        (wb_dat_i),
    .wb_dat_o        (wb_dat_o),
    .wb_ack_o        (wb_ack_o),
    .wb_int_o        (wb_int_o),
    .status_i        (status_i),
    .ctrl_tx_enable_o(ctrl_tx_enable_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // One classic access: strobe for one edge, then report ack after that edge,
  // ack after the following edge, and the data held in that ack cycle.
  task automatic bus(input logic [7:0] adr, input logic we, input logic [31:0] wdat,
                     output logic [31:0] rdat, output logic ack_k, output logic ack_k1);
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = wdat;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    tick();
    ack_k = wb_ack_o;
    rdat  = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    tick();
    ack_k1 = wb_ack_o;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic a0, a1;
    logic [7:0] addrs [4] = '{8'h00, 8'h04, 8'h08, 8'h10};
    tick();
    tests_run++;
    if ({wb_ack_o, wb_int_o, ctrl_tx_enable_o, wb_dat_o} !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got ack=%b int=%b txen=%b dat=%h, want all 0",
               wb_ack_o, wb_int_o, ctrl_tx_enable_o, wb_dat_o);
    end
    wb_rst_i = 1'b0;
    tick();
    foreach (addrs[i]) begin
      bus(addrs[i], 1'b0, 32'h0, rd, a0, a1);
      tests_run++;
      if (rd !== 32'h0 || a0 !== 1'b1 || a1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_read_%h: got dat=%h ack=%b%b, want dat=0 ack=10", addrs[i], rd, a0, a1);
      end
    end
  endtask

  task automatic test_rw();
    logic [31:0] rd;
    logic a0, a1;
    bus(8'h04, 1'b1, 32'hDEADBEEF, rd, a0, a1);
    tests_run++;
    if (a0 !== 1'b1 || a1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_ack: got %b%b, want 10", a0, a1);
    end
    bus(8'h04, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL scratch_rb: got %h, want deadbeef", rd);
    end
    bus(8'h00, 1'b1, 32'h3, rd, a0, a1);
    tests_run++;
    if (ctrl_tx_enable_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_enable: got %b, want 1", ctrl_tx_enable_o);
    end
    bus(8'h00, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h1) begin
      tests_failed++;
      $display("FAIL config_rb: got %h, want 00000001", rd);
    end
    bus(8'h10, 1'b1, 32'hFFFFFFFF, rd, a0, a1);
    bus(8'h10, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h1FF) begin
      tests_failed++;
      $display("FAIL mask_width: got %h, want 000001ff", rd);
    end
    bus(8'h10, 1'b1, 32'h0, rd, a0, a1);
  endtask

  task automatic test_interrupt();
    logic [31:0] rd;
    logic a0, a1;
    status_i = 9'h001;
    repeat (10) tick();
    tests_run++;
    if (wb_int_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL int_masked: got %b, want 0", wb_int_o);
    end
    // Mask write commits at the first edge; interrupt must be visible right after it.
    wb_adr_i = 8'h10; wb_we_i = 1'b1; wb_dat_i = 32'h1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tests_run++;
    if (wb_int_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL int_unmasked: got %b, want 1", wb_int_o);
    end
    tick();
    bus(8'h08, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h1 || wb_int_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL pending_cor: got dat=%h int=%b, want dat=00000001 int=0", rd, wb_int_o);
    end
    bus(8'h08, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL pending_reread: got %h, want 0", rd);
    end
    bus(8'h10, 1'b1, 32'h0, rd, a0, a1);
  endtask

  task automatic test_clear_race();
    logic [31:0] rd;
    logic a0, a1;
    status_i = 9'h003;            // bit1 rises -> pending 0x002
    tick();
    status_i = 9'h00B;            // bit3 rises on the clearing read's commit edge
    bus(8'h08, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h2) begin
      tests_failed++;
      $display("FAIL race_prior: got %h, want 00000002", rd);
    end
    bus(8'h08, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h8) begin
      tests_failed++;
      $display("FAIL race_after: got %h, want 00000008", rd);
    end
    bus(8'h0C, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h00B) begin
      tests_failed++;
      $display("FAIL int_status: got %h, want 0000000b", rd);
    end
    status_i = 9'h000;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic a0, a1;
    bus(8'h04, 1'b0, 32'h0, rd, a0, a1);   // leave a non-zero value in wb_dat_o
    bus(8'h1C, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h0 || a0 !== 1'b1 || a1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL unmapped_read: got dat=%h ack=%b%b, want dat=0 ack=10", rd, a0, a1);
    end
    bus(8'h1C, 1'b1, 32'h12345678, rd, a0, a1);
    bus(8'h04, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL unmapped_write: scratch got %h, want deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    wb_adr_i = 8'h04; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (wb_ack_o === 1'b1) acks++;
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tests_run++;
    if (acks !== 3) begin
      tests_failed++;
      $display("FAIL back_to_back: got %0d acks, want 3", acks);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    logic a0, a1;
    wb_adr_i = 8'h04; wb_we_i = 1'b1; wb_dat_i = 32'hCAFEF00D; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick();
    wb_rst_i = 1'b1;
    #1;
    tests_run++;
    if (wb_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_ack_drop: got %b, want 0", wb_ack_o);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tick();
    wb_rst_i = 1'b0;
    tick();
    bus(8'h04, 1'b0, 32'h0, rd, a0, a1);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_scratch: got %h, want 0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_interrupt();
    test_clear_race();
    test_unmapped();
    test_back_to_back();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
